// File: rtl/noc_switch_allocator.sv
`default_nettype none
// ============================================================================
// noc_switch_allocator : wormhole, round-robin output allocator that drives
//                        the port selects of a 5-port NOC crossbar.
// Revision: 1.0
// ============================================================================
module noc_switch_allocator #(
  parameter int                 NPORTS   = 5,
  parameter int                 SEL_W    = 3,
  parameter logic [SEL_W-1:0]   IDLE_SEL = 3'b111
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NPORTS-1:0]         req_valid_i,
  input  logic [NPORTS*SEL_W-1:0]   req_dest_i,
  input  logic [NPORTS-1:0]         req_head_i,
  input  logic [NPORTS-1:0]         req_tail_i,
  input  logic [NPORTS-1:0]         out_ready_i,
  output logic [NPORTS-1:0]         req_ready_o,
  output logic [SEL_W-1:0]          N_port_select,
  output logic [SEL_W-1:0]          S_port_select,
  output logic [SEL_W-1:0]          E_port_select,
  output logic [SEL_W-1:0]          W_port_select,
  output logic [SEL_W-1:0]          L_port_select,
  output logic [NPORTS-1:0]         sel_valid_o,
  output logic                      err_o
);

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t             r_state     [NPORTS];
  state_t             w_state_nxt [NPORTS];
  logic [SEL_W-1:0]   r_owner     [NPORTS];
  logic [SEL_W-1:0]   w_owner_nxt [NPORTS];
  logic [SEL_W-1:0]   r_rr        [NPORTS];
  logic [SEL_W-1:0]   w_rr_nxt    [NPORTS];
  logic [SEL_W-1:0]   w_dest      [NPORTS];
  logic [NPORTS-1:0]  w_cand      [NPORTS];
  logic [SEL_W:0]     w_pick      [NPORTS];
  logic [NPORTS-1:0]  w_owned;
  logic [NPORTS-1:0]  w_xfer;
  logic [NPORTS-1:0]  w_tail_own;

  // Returns {found, index}; scanning backwards leaves the first hit after ptr.
  function automatic logic [SEL_W:0] f_rr_pick(input logic [NPORTS-1:0] cand,
                                               input logic [SEL_W-1:0]  ptr);
    logic [SEL_W:0] res;
    int             idx;
    res = {1'b0, IDLE_SEL};
    for (int k = NPORTS; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NPORTS;
      if (cand[idx]) res = {1'b1, SEL_W'(idx)};
    end
    return res;
  endfunction

  always_comb begin
    for (int i = 0; i < NPORTS; i++) w_dest[i] = req_dest_i[SEL_W*i +: SEL_W];
  end

  always_comb begin
    w_owned = '0;
    for (int o = 0; o < NPORTS; o++)
      for (int i = 0; i < NPORTS; i++)
        if (r_state[o] == ST_LOCKED && r_owner[o] == SEL_W'(i)) w_owned[i] = 1'b1;
  end

  always_comb begin
    req_ready_o = '0;
    w_xfer      = '0;
    w_tail_own  = '0;
    for (int o = 0; o < NPORTS; o++)
      for (int i = 0; i < NPORTS; i++)
        if (r_state[o] == ST_LOCKED && r_owner[o] == SEL_W'(i)) begin
          w_tail_own[o] = req_tail_i[i];
          if (req_valid_i[i] && out_ready_i[o] && w_dest[i] == SEL_W'(o)) begin
            req_ready_o[i] = 1'b1;
            w_xfer[o]      = 1'b1;
          end
        end
  end

  always_comb begin
    err_o = 1'b0;
    for (int i = 0; i < NPORTS; i++)
      if (req_valid_i[i] && req_head_i[i] &&
          (w_dest[i] >= SEL_W'(NPORTS) || w_dest[i] == SEL_W'(i)))
        err_o = 1'b1;
  end

  // U-turns and inputs already held by another output never become candidates.
  always_comb begin
    for (int o = 0; o < NPORTS; o++) begin
      for (int i = 0; i < NPORTS; i++)
        w_cand[o][i] = req_valid_i[i] && req_head_i[i] && (w_dest[i] == SEL_W'(o)) &&
                       (i != o) && !w_owned[i];
      w_pick[o] = f_rr_pick(w_cand[o], r_rr[o]);
    end
  end

  always_comb begin
    for (int o = 0; o < NPORTS; o++) begin
      w_state_nxt[o] = r_state[o];
      w_owner_nxt[o] = r_owner[o];
      w_rr_nxt[o]    = r_rr[o];
      case (r_state[o])
        ST_IDLE: begin
          if (w_pick[o][SEL_W]) begin
            w_state_nxt[o] = ST_LOCKED;
            w_owner_nxt[o] = w_pick[o][SEL_W-1:0];
            w_rr_nxt[o]    = w_pick[o][SEL_W-1:0];
          end
        end
        ST_LOCKED: begin
          if (w_xfer[o] && w_tail_own[o]) begin
            w_state_nxt[o] = ST_IDLE;
            w_owner_nxt[o] = IDLE_SEL;
          end
        end
        default: begin
          w_state_nxt[o] = ST_IDLE;
          w_owner_nxt[o] = IDLE_SEL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int o = 0; o < NPORTS; o++) begin
        r_state[o] <= ST_IDLE;
        r_owner[o] <= IDLE_SEL;
        r_rr[o]    <= SEL_W'(NPORTS - 1);
      end
    end else begin
      for (int o = 0; o < NPORTS; o++) begin
        r_state[o] <= w_state_nxt[o];
        r_owner[o] <= w_owner_nxt[o];
        r_rr[o]    <= w_rr_nxt[o];
      end
    end
  end

  always_comb begin
    for (int o = 0; o < NPORTS; o++) sel_valid_o[o] = (r_state[o] == ST_LOCKED);
  end

  assign N_port_select = r_owner[0];
  assign S_port_select = r_owner[1];
  assign E_port_select = r_owner[2];
  assign W_port_select = r_owner[3];
  assign L_port_select = r_owner[4];

endmodule
`default_nettype wire

// File: tb/tb_noc_switch_allocator.sv
`default_nettype none
// ============================================================================
// tb_noc_switch_allocator : table-driven bench for noc_switch_allocator.
// Revision: 1.0
// ============================================================================
module tb_noc_switch_allocator;

  typedef struct {
    bit          chk;
    logic        rst_n;
    logic [4:0]  v;
    logic [14:0] d;
    logic [4:0]  h;
    logic [4:0]  t;
    logic [4:0]  ordy;
    logic [4:0]  ery;
    logic [14:0] esel;
    logic [4:0]  esv;
    logic        eerr;
  } vec_t;

  localparam logic [14:0] ISEL = 15'h7FFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  req_valid_i, req_head_i, req_tail_i, out_ready_i;
  logic [14:0] req_dest_i;
  logic [4:0]  req_ready_o, sel_valid_o;
  logic [2:0]  N_port_select, S_port_select, E_port_select, W_port_select, L_port_select;
  logic        err_o;
  logic [14:0] w_sel;

  int total = 0;
  int bad   = 0;
  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  noc_switch_allocator dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_dest_i(req_dest_i),
    .req_head_i(req_head_i), .req_tail_i(req_tail_i),
    .out_ready_i(out_ready_i), .req_ready_o(req_ready_o),
    .N_port_select(N_port_select), .S_port_select(S_port_select),
    .E_port_select(E_port_select), .W_port_select(W_port_select),
    .L_port_select(L_port_select), .sel_valid_o(sel_valid_o), .err_o(err_o)
  );

  assign w_sel = {L_port_select, W_port_select, E_port_select, S_port_select, N_port_select};

  function automatic logic [14:0] p5(input logic [2:0] n, s, e, w, l);
    return {l, w, e, s, n};
  endfunction

  task automatic add(input bit chk, input logic rst, input logic [4:0] v, input logic [14:0] d,
                     input logic [4:0] h, input logic [4:0] t, input logic [4:0] ordy,
                     input logic [4:0] ery, input logic [14:0] esel, input logic [4:0] esv,
                     input logic eerr);
    vec_t r;
    r.chk = chk; r.rst_n = rst; r.v = v; r.d = d; r.h = h; r.t = t; r.ordy = ordy;
    r.ery = ery; r.esel = esel; r.esv = esv; r.eerr = eerr;
    tbl.push_back(r);
  endtask

  task automatic add_rst();
    add(0, 0, 5'b0, ISEL, 5'b0, 5'b0, 5'h1F, 5'b0, ISEL, 5'b0, 0);
  endtask

  task automatic idle_row(input logic eerr);
    add(1, 1, 5'b0, ISEL, 5'b0, 5'b0, 5'h1F, 5'b0, ISEL, 5'b0, eerr);
  endtask

  task automatic cmp(input string nm, input int row, input logic [14:0] got, input logic [14:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %h want %h", nm, row, got, exp);
    end
  endtask

  initial begin
    vec_t e;
    rst_n = 1'b0; req_valid_i = '0; req_dest_i = ISEL; req_head_i = '0;
    req_tail_i = '0; out_ready_i = 5'h1F;

    // Single-flit W -> E, then reset-state check before it.
    add_rst(); add_rst();
    idle_row(0);
    add(1, 1, 5'b01000, p5(7,7,7,2,7), 5'b01000, 5'b01000, 5'h1F, 5'b00000, ISEL, 5'b00000, 0);
    add(1, 1, 5'b01000, p5(7,7,7,2,7), 5'b01000, 5'b01000, 5'h1F, 5'b01000, p5(7,7,3,7,7), 5'b00100, 0);
    idle_row(0);

    // N, S, L contend for E: N, S, L, N with a bubble between grants.
    add_rst();
    add(1, 1, 5'b10011, p5(2,2,7,7,2), 5'b10011, 5'b10011, 5'h1F, 5'b00000, ISEL, 5'b00000, 0);
    add(1, 1, 5'b10011, p5(2,2,7,7,2), 5'b10011, 5'b10011, 5'h1F, 5'b00001, p5(7,7,0,7,7), 5'b00100, 0);
    add(1, 1, 5'b10011, p5(2,2,7,7,2), 5'b10011, 5'b10011, 5'h1F, 5'b00000, ISEL, 5'b00000, 0);
    add(1, 1, 5'b10011, p5(2,2,7,7,2), 5'b10011, 5'b10011, 5'h1F, 5'b00010, p5(7,7,1,7,7), 5'b00100, 0);
    add(1, 1, 5'b10011, p5(2,2,7,7,2), 5'b10011, 5'b10011, 5'h1F, 5'b00000, ISEL, 5'b00000, 0);
    add(1, 1, 5'b10011, p5(2,2,7,7,2), 5'b10011, 5'b10011, 5'h1F, 5'b10000, p5(7,7,4,7,7), 5'b00100, 0);
    add(1, 1, 5'b10011, p5(2,2,7,7,2), 5'b10011, 5'b10011, 5'h1F, 5'b00000, ISEL, 5'b00000, 0);
    add(1, 1, 5'b10011, p5(2,2,7,7,2), 5'b10011, 5'b10011, 5'h1F, 5'b00001, p5(7,7,0,7,7), 5'b00100, 0);

    // 3-flit L -> N with N downstream stalled for two cycles.
    add_rst();
    add(1, 1, 5'b10000, p5(7,7,7,7,0), 5'b10000, 5'b00000, 5'h1F, 5'b00000, ISEL, 5'b00000, 0);
    add(1, 1, 5'b10000, p5(7,7,7,7,0), 5'b10000, 5'b00000, 5'h1F, 5'b10000, p5(4,7,7,7,7), 5'b00001, 0);
    add(1, 1, 5'b10000, p5(7,7,7,7,0), 5'b00000, 5'b00000, 5'h1E, 5'b00000, p5(4,7,7,7,7), 5'b00001, 0);
    add(1, 1, 5'b10000, p5(7,7,7,7,0), 5'b00000, 5'b00000, 5'h1E, 5'b00000, p5(4,7,7,7,7), 5'b00001, 0);
    add(1, 1, 5'b10000, p5(7,7,7,7,0), 5'b00000, 5'b00000, 5'h1F, 5'b10000, p5(4,7,7,7,7), 5'b00001, 0);
    add(1, 1, 5'b10000, p5(7,7,7,7,0), 5'b00000, 5'b10000, 5'h1F, 5'b10000, p5(4,7,7,7,7), 5'b00001, 0);
    idle_row(0);

    // Concurrent N -> S and E -> W.
    add_rst();
    add(1, 1, 5'b00101, p5(1,7,3,7,7), 5'b00101, 5'b00101, 5'h1F, 5'b00000, ISEL, 5'b00000, 0);
    add(1, 1, 5'b00101, p5(1,7,3,7,7), 5'b00101, 5'b00101, 5'h1F, 5'b00101, p5(7,0,7,2,7), 5'b01010, 0);
    idle_row(0);

    // Illegal heads (U-turn, dest 6) and a non-head flit at an idle output.
    add_rst();
    add(1, 1, 5'b00010, p5(7,1,7,7,7), 5'b00010, 5'b00010, 5'h1F, 5'b00000, ISEL, 5'b00000, 1);
    add(1, 1, 5'b00010, p5(7,1,7,7,7), 5'b00010, 5'b00010, 5'h1F, 5'b00000, ISEL, 5'b00000, 1);
    add(1, 1, 5'b00100, p5(7,7,6,7,7), 5'b00100, 5'b00100, 5'h1F, 5'b00000, ISEL, 5'b00000, 1);
    add(1, 1, 5'b00100, p5(7,7,6,7,7), 5'b00100, 5'b00100, 5'h1F, 5'b00000, ISEL, 5'b00000, 1);
    add(1, 1, 5'b00001, p5(1,7,7,7,7), 5'b00000, 5'b00000, 5'h1F, 5'b00000, ISEL, 5'b00000, 0);
    add(1, 1, 5'b00001, p5(1,7,7,7,7), 5'b00000, 5'b00000, 5'h1F, 5'b00000, ISEL, 5'b00000, 0);
    idle_row(0);

    // Reset mid-packet N -> L, then N and W race for L from a fresh pointer.
    add_rst();
    add(1, 1, 5'b00001, p5(4,7,7,7,7), 5'b00001, 5'b00000, 5'h1F, 5'b00000, ISEL, 5'b00000, 0);
    add(1, 1, 5'b00001, p5(4,7,7,7,7), 5'b00001, 5'b00000, 5'h1F, 5'b00001, p5(7,7,7,7,0), 5'b10000, 0);
    add(1, 1, 5'b00001, p5(4,7,7,7,7), 5'b00000, 5'b00000, 5'h1F, 5'b00001, p5(7,7,7,7,0), 5'b10000, 0);
    add(1, 0, 5'b00001, p5(4,7,7,7,7), 5'b00000, 5'b00000, 5'h1F, 5'b00001, p5(7,7,7,7,0), 5'b10000, 0);
    add(1, 1, 5'b01001, p5(4,7,7,4,7), 5'b01001, 5'b01001, 5'h1F, 5'b00000, ISEL, 5'b00000, 0);
    add(1, 1, 5'b01001, p5(4,7,7,4,7), 5'b01001, 5'b01001, 5'h1F, 5'b00001, p5(7,7,7,7,0), 5'b10000, 0);
    add(1, 1, 5'b01000, p5(7,7,7,4,7), 5'b01000, 5'b01000, 5'h1F, 5'b00000, ISEL, 5'b00000, 0);
    add(1, 1, 5'b01000, p5(7,7,7,4,7), 5'b01000, 5'b01000, 5'h1F, 5'b01000, p5(7,7,7,7,3), 5'b10000, 0);
    idle_row(0);

    for (int n = 0; n < tbl.size(); n++) begin
      @(negedge clk);
      rst_n       = tbl[n].rst_n;
      req_valid_i = tbl[n].v;
      req_dest_i  = tbl[n].d;
      req_head_i  = tbl[n].h;
      req_tail_i  = tbl[n].t;
      out_ready_i = tbl[n].ordy;
      sb.push_back(tbl[n]);
      #1;
      e = sb.pop_front();
      if (e.chk) begin
        cmp("req_ready", n, {10'b0, req_ready_o}, {10'b0, e.ery});
        cmp("port_sel",  n, w_sel, e.esel);
        cmp("sel_valid", n, {10'b0, sel_valid_o}, {10'b0, e.esv});
        cmp("err",       n, {14'b0, err_o}, {14'b0, e.eerr});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
